// File: rtl/vx_wrr_packet_arb_pkg.sv
// Shared definitions for the weighted round-robin packet arbiter.
// Holds the lock-state encoding and the select-width helper used by the top level.
package vx_wrr_packet_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_wrr_packet_arb_skid.sv
// Output stage of the packet arbiter: a two-entry skid buffer sustaining one beat per
// cycle with a registered output, or a plain wire-through when PASSTHRU is set.
module vx_wrr_packet_arb_skid #(
  parameter int DATAW    = 1,
  parameter bit PASSTHRU = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);

  if (PASSTHRU) begin : g_pass
    logic unused_clk;
    assign unused_clk = clk;
    assign valid_out  = valid_in & rst_n;
    assign data_out   = data_in;
    assign ready_in   = ready_out & rst_n;
  end else begin : g_reg
    logic             vld_p1;
    logic [DATAW-1:0] dat_p1;
    logic             skid_vld_p1;
    logic [DATAW-1:0] skid_dat_p1;

    // Input is accepted whenever the spill slot is free, so a stall costs no bubble.
    assign ready_in  = rst_n & ~skid_vld_p1;
    assign valid_out = vld_p1;
    assign data_out  = dat_p1;

    // Stage p1: output register plus spill slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p1      <= 1'b0;
        dat_p1      <= '0;
        skid_vld_p1 <= 1'b0;
        skid_dat_p1 <= '0;
      end else if (!vld_p1 || ready_out) begin
        if (skid_vld_p1) begin
          vld_p1      <= 1'b1;
          dat_p1      <= skid_dat_p1;
          skid_vld_p1 <= 1'b0;
        end else begin
          vld_p1 <= valid_in;
          if (valid_in) dat_p1 <= data_in;
        end
      end else if (valid_in && !skid_vld_p1) begin
        skid_vld_p1 <= 1'b1;
        skid_dat_p1 <= data_in;
      end
    end
  end

endmodule

// File: rtl/vx_wrr_packet_arb.sv
// Weighted round-robin packet arbiter: grants are held for a whole packet and each
// input may send weight[i]+1 packets in a row before priority moves on.
module vx_wrr_packet_arb
  import vx_wrr_packet_arb_pkg::*;
#(
  parameter int  NUM_INPUTS = 4,
  parameter int  DATAW      = 32,
  parameter int  WEIGHTW    = 4,
  parameter int  OUT_REG    = 1,
  localparam int SELW       = sel_width(NUM_INPUTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_INPUTS-1:0]         valid_in,
  input  logic [NUM_INPUTS*DATAW-1:0]   data_in,
  input  logic [NUM_INPUTS-1:0]         last_in,
  output logic [NUM_INPUTS-1:0]         ready_in,
  input  logic [NUM_INPUTS*WEIGHTW-1:0] weight,
  output logic                          valid_out,
  output logic [DATAW-1:0]              data_out,
  output logic                          last_out,
  output logic [SELW-1:0]               sel_out,
  input  logic                          ready_out
);

  arb_state_e         state;
  logic [SELW-1:0]    owner;
  logic [SELW-1:0]    prio;
  logic [WEIGHTW-1:0] used;

  logic [SELW-1:0]    pick;
  logic [SELW-1:0]    sel;
  logic [SELW-1:0]    sel_next;
  logic [WEIGHTW-1:0] used_eff;
  logic [WEIGHTW-1:0] w_sel;
  logic [DATAW-1:0]   beat_data;
  logic               beat_last;
  logic               grant_valid;
  logic               arb_ready;
  logic               fire;

  function automatic logic [SELW-1:0] rr_pick(input logic [NUM_INPUTS-1:0] req,
                                               input logic [SELW-1:0]       start);
    logic [SELW-1:0] idx;
    logic            found;
    rr_pick = start;
    found   = 1'b0;
    idx     = start;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
      idx = (idx == SELW'(NUM_INPUTS - 1)) ? '0 : idx + 1'b1;
    end
  endfunction

  assign pick        = rr_pick(valid_in, prio);
  assign sel         = (state == ARB_LOCKED) ? owner : pick;
  assign grant_valid = reset & ((state == ARB_LOCKED) ? valid_in[owner] : |valid_in);
  assign fire        = grant_valid & arb_ready;
  assign used_eff    = (sel == prio) ? used : '0;
  assign sel_next    = (sel == SELW'(NUM_INPUTS - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    beat_data = '0;
    beat_last = 1'b0;
    w_sel     = '0;
    ready_in  = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (sel == SELW'(i)) begin
        beat_data   = data_in[i*DATAW +: DATAW];
        beat_last   = last_in[i];
        w_sel       = weight[i*WEIGHTW +: WEIGHTW];
        ready_in[i] = arb_ready & reset;
      end
    end
  end

  // Lock and weighted rotation; weights are sampled only when a packet completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB_IDLE;
      owner <= '0;
      prio  <= '0;
      used  <= '0;
    end else if (fire) begin
      if (beat_last) begin
        state <= ARB_IDLE;
        if (NUM_INPUTS > 1) begin
          if (used_eff >= w_sel) begin
            prio <= sel_next;
            used <= '0;
          end else begin
            prio <= sel;
            used <= used_eff + 1'b1;
          end
        end
      end else if (state == ARB_IDLE) begin
        state <= ARB_LOCKED;
        owner <= sel;
      end
    end
  end

  logic [DATAW+SELW:0] out_bundle;

  vx_wrr_packet_arb_skid #(
    .DATAW    (DATAW + 1 + SELW),
    .PASSTHRU (OUT_REG == 0)
  ) u_out (
    .clk       (clk),
    .rst_n     (reset),
    .valid_in  (grant_valid),
    .data_in   ({beat_last, sel, beat_data}),
    .ready_in  (arb_ready),
    .valid_out (valid_out),
    .data_out  (out_bundle),
    .ready_out (ready_out)
  );

  assign {last_out, sel_out, data_out} = out_bundle;

endmodule

// File: tb/tb_vx_wrr_packet_arb.sv
// Directed bench for vx_wrr_packet_arb: sources are driven from per-input beat queues,
// expected beats go into a scoreboard queue that a separate monitor pops.
module tb_vx_wrr_packet_arb;

  localparam int N = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic            clk;
  logic            reset;
  logic [N-1:0]    valid_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    last_in;
  logic [N-1:0]    ready_in;
  logic [N*WW-1:0] weight;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic            last_out;
  logic [1:0]      sel_out;
  logic            ready_out;

  vx_wrr_packet_arb #(
    .NUM_INPUTS (N),
    .DATAW      (DW),
    .WEIGHTW    (WW),
    .OUT_REG    (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .last_in   (last_in),
    .ready_in  (ready_in),
    .weight    (weight),
    .valid_out (valid_out),
    .data_out  (data_out),
    .last_out  (last_out),
    .sel_out   (sel_out),
    .ready_out (ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [32:0] src_q [N][$];
  logic [34:0] exp_q [$];
  int          pop_cyc [$];
  logic [N-1:0] hold;

  function automatic logic [31:0] mkd(input int s, input int p, input int b);
    return {8'(s), 8'(p), 16'(b)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic add_pkt(input int s, input int p, input int n);
    for (int b = 0; b < n; b++) src_q[s].push_back({(b == n - 1), mkd(s, p, b)});
  endtask

  task automatic exp_pkt(input int s, input int p, input int n);
    for (int b = 0; b < n; b++) exp_q.push_back({2'(s), (b == n - 1), mkd(s, p, b)});
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0 && !hold[i]) begin
        valid_in[i]          = 1'b1;
        data_in[i*DW +: DW]  = src_q[i][0][31:0];
        last_in[i]           = src_q[i][0][32];
      end else begin
        valid_in[i]          = 1'b0;
        data_in[i*DW +: DW]  = '0;
        last_in[i]           = 1'b0;
      end
    end
  endtask

  // Called at posedge+1; leaves the bench at the middle of the cycle.
  task automatic cyc_begin();
    drive_inputs();
    #4;
  endtask

  task automatic cyc_end();
    logic [N-1:0] f;
    #4;
    f = valid_in & ready_in;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (f[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    cyc++;
  endtask

  function automatic bit busy();
    bit b = (exp_q.size() > 0);
    for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      cyc_begin();
      cyc_end();
      n++;
    end
    if (busy()) begin
      total++;
      bad++;
      $display("FAIL %s_timeout pending_exp=%0d required=0", name, exp_q.size());
      exp_q.delete();
      for (int i = 0; i < N; i++) src_q[i].delete();
    end
  endtask

  // Monitor: every accepted output beat is matched against the scoreboard.
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (reset && valid_out && ready_out) begin
        pop_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat actual=%0h required=none", {sel_out, last_out, data_out});
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", 64'({sel_out, last_out, data_out}), 64'(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=stuck required=finish");
    $fatal(1);
  end

  int order2 [14] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0, 1, 2, 2, 3};

  initial begin
    int mark;
    int pc [N];
    int n;
    logic [31:0] held;

    reset     = 1'b0;
    ready_out = 1'b1;
    weight    = '0;
    hold      = '0;
    valid_in  = '0;
    data_in   = '0;
    last_in   = '0;
    @(posedge clk);
    #1;

    // Reset state, with requests already pending
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) add_pkt(i, p, 1);
    for (int k = 0; k < 2; k++) begin
      cyc_begin();
      chk("rst_valid_out", 64'(valid_out), 64'd0);
      chk("rst_ready_in", 64'(ready_in), 64'd0);
      chk("rst_outputs", 64'({data_out, last_out, sel_out}), 64'd0);
      cyc_end();
    end
    reset = 1'b1;

    // Equal weights: plain round robin, one beat per cycle
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < N; i++) exp_pkt(i, p, 1);
    mark = pop_cyc.size();
    drain("rr_equal", 60);
    if (pop_cyc.size() >= mark + 12)
      chk("rr_equal_rate", 64'(pop_cyc[mark+11] - pop_cyc[mark]), 64'd11);

    // Weights {2,0,1,0}: 0,0,0,1,2,2,3 twice
    weight = 16'h0102;
    for (int i = 0; i < N; i++) pc[i] = 0;
    for (int k = 0; k < 14; k++) begin
      add_pkt(order2[k], 10 + pc[order2[k]], 1);
      exp_pkt(order2[k], 10 + pc[order2[k]], 1);
      pc[order2[k]]++;
    end
    mark = pop_cyc.size();
    drain("wrr", 80);
    if (pop_cyc.size() >= mark + 14)
      chk("wrr_rate", 64'(pop_cyc[mark+13] - pop_cyc[mark]), 64'd13);
    weight = '0;

    // Move prio to 1, then a 4-beat packet from 1 against a busy input 0
    add_pkt(0, 20, 1);
    exp_pkt(0, 20, 1);
    drain("prep", 20);
    add_pkt(1, 21, 4);
    add_pkt(0, 22, 1);
    add_pkt(0, 23, 1);
    exp_pkt(1, 21, 4);
    exp_pkt(0, 22, 1);
    exp_pkt(0, 23, 1);
    drain("multibeat", 40);

    // Owner stalls mid-packet for three cycles while input 3 waits
    add_pkt(2, 30, 4);
    add_pkt(3, 31, 1);
    exp_pkt(2, 30, 4);
    exp_pkt(3, 31, 1);
    n = 0;
    while (src_q[2].size() > 2 && n < 20) begin cyc_begin(); cyc_end(); n++; end
    chk("bubble_start", 64'(src_q[2].size()), 64'd2);
    hold[2] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j == 3) hold[2] = 1'b0;
      cyc_begin();
      if (j < 3) chk("bubble_ready_other", 64'(ready_in[3]), 64'd0);
      if (j > 0) chk("bubble_valid_out", 64'(valid_out), 64'd0);
      cyc_end();
    end
    drain("bubble", 40);

    // Downstream backpressure for five cycles in the middle of a packet
    add_pkt(0, 40, 4);
    exp_pkt(0, 40, 4);
    n = 0;
    while (src_q[0].size() > 2 && n < 20) begin cyc_begin(); cyc_end(); n++; end
    ready_out = 1'b0;
    held = '0;
    for (int j = 0; j < 5; j++) begin
      cyc_begin();
      if (j == 0) held = data_out;
      else begin
        chk("stall_data_stable", 64'(data_out), 64'(held));
        chk("stall_ready_in", 64'(ready_in), 64'd0);
      end
      cyc_end();
    end
    ready_out = 1'b1;
    drain("stall", 40);

    // Reset in the middle of a locked packet from input 1
    add_pkt(1, 50, 4);
    exp_q.push_back({2'd1, 1'b0, mkd(1, 50, 0)});
    n = 0;
    while (src_q[1].size() > 2 && n < 20) begin cyc_begin(); cyc_end(); n++; end
    reset = 1'b0;
    #1;
    chk("midrst_valid_out", 64'(valid_out), 64'd0);
    chk("midrst_ready_in", 64'(ready_in), 64'd0);
    src_q[1].delete();
    #3;
    cyc_end();
    reset = 1'b1;
    add_pkt(1, 51, 4);
    add_pkt(0, 52, 1);
    exp_pkt(0, 52, 1);
    exp_pkt(1, 51, 4);
    drain("after_rst", 40);

    cyc_begin();
    cyc_end();
    chk("final_idle", 64'(valid_out), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_wrr_packet_arb.md
# vx_wrr_packet_arb

Weighted round-robin packet arbiter sharing one output stream between NUM_INPUTS multi-beat packet sources. Grants are held from the first beat to the `last` beat of a packet, so packets are never interleaved. Each input may send weight[i]+1 consecutive packets per turn before priority rotates. It sits in front of shared memory and interconnect ports, where the plain stream arbiter's per-beat lock is insufficient.

## Interface
- NUM_INPUTS, 4: number of requesters; must be ≥1.
- DATAW, 32: payload width per beat.
- WEIGHTW, 4: width of each per-input weight field.
- OUT_REG, 1: 1 = output through a skid buffer (registered, full throughput); 0 = combinational pass-through.
- SELW (localparam): `CLOG2(NUM_INPUTS)`, minimum 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserted when 0.
- valid_in  in  NUM_INPUTS  per-input beat valid.
- data_in  in  NUM_INPUTS×DATAW  per-input payload.
- last_in  in  NUM_INPUTS  per-input final-beat-of-packet flag.
- ready_in  out  NUM_INPUTS  per-input accept; at most one bit is set.
- weight  in  NUM_INPUTS×WEIGHTW  quasi-static configuration; extra packets per turn.
- valid_out  out  1  output beat valid.
- data_out  out  DATAW  output payload.
- last_out  out  1  output final-beat flag.
- sel_out  out  SELW  index of the source of the current output beat.
- ready_out  in  1  downstream accept.

## Operation
- State registers:
  - locked (1b)
  - owner (SELW): the input holding the lock
  - prio (SELW): the input with highest priority
  - used (WEIGHTW): packets already sent by prio in its current turn
- IDLE (locked=0), grant selection:
  - Scan valid_in circularly, starting at prio.
  - The first valid input is granted in the same cycle, and its first beat is offered downstream.
- Lock entry: in IDLE, if the granted input's beat is accepted with last_in=0, set locked=1 and owner=granted index.
- LOCKED:
  - Only owner is muxed through, and only ready_in[owner] may be 1.
  - Other inputs are ignored regardless of their valid.
  - If owner deasserts valid mid-packet, the output bubbles and the lock holds.
- Lock exit and rotation:
  - When a last beat from input s is accepted (in IDLE or LOCKED), set locked=0.
  - Let u = (s==prio) ? used : 0.
  - If u ≥ weight[s]: prio = (s+1) mod NUM_INPUTS and used = 0.
  - Else: prio = s and used = u+1.
- A single-beat packet (last_in=1 on the first beat) never enters LOCKED; it updates prio and used only.
- weight is read only at packet completion. A change mid-turn takes effect at the next completion.
- Handshake:
  - A beat transfers on the input side when valid_in[i] & ready_in[i].
  - ready_in[i] = internal_ready & grant[i].
  - internal_ready is ready_out when OUT_REG=0, or the skid buffer's ready when OUT_REG=1.
  - Once valid_out is asserted, it is not withdrawn until accepted.
- NUM_INPUTS=1: input 0 is always granted, sel_out=0, and the weight logic is inert.

## Timing
- Reset (reset=0):
  - locked=0, prio=0, used=0, owner=0.
  - valid_out=0 and ready_in=0 for the whole time reset is asserted.
  - data_out, last_out and sel_out are 0 when OUT_REG=1.
- Reset mid-packet discards the lock. The source must restart the packet.
- OUT_REG=0: zero latency; valid and data paths are combinational from the inputs to the outputs.
- OUT_REG=1: first beat appears one cycle after acceptance. One beat per cycle is sustained under continuous ready_out.
- Arbitration adds no bubble between back-to-back packets. The cycle after a last beat is accepted, the next grant is already offered.
- Backpressure: when ready_out=0, the owner's beat is held, no state changes, and the grant is stable.
- Simultaneous last-beat acceptance and new requests: the new grant uses the updated prio from that edge.

## Structure
- No shared package types are required. SELW and the `CLOG2` / `MIN` macros come from the platform header.
- Circular priority pick: one small combinational function inside the module. The generic arbiter is not reused, because the weight rotation is custom.
- Output stage: instantiate VX_skid_buffer with DATAW+1+SELW bits, PASSTHRU=(OUT_REG==0).

## Test plan
- All 4 inputs continuously valid with 1-beat packets, weights 0: grants come out 0,1,2,3,0,… with one beat per cycle.
- Weights {2,0,1,0}, all inputs valid with 1-beat packets: sel_out sequence is 0,0,0,1,2,2,3, repeating.
- Input 1 sends a 4-beat packet while input 0 is valid throughout: four consecutive beats with sel_out=1, no interleaving. Input 0 is granted next only if prio points to it, otherwise the scan continues.
- Owner drops valid for 3 cycles mid-packet while others are valid: valid_out=0 for those cycles, then the packet resumes from the same owner.
- ready_out=0 for 5 cycles during a packet: data_out is stable, ready_in is all 0, and no beat is lost or duplicated (scoreboard).
- Assert reset during a locked 4-beat packet after 2 beats: valid_out=0 and ready_in=0 immediately. After release, prio=0 and input 0 is granted first.
